// File: rtl/robertson_seq.sv
// Robertson signed shift-add multiplier: one add/subtract per clock over dw iterations,
// with a final subtract that corrects for the weight of the multiplier sign bit.
module robertson_seq #(
    parameter int unsigned dw = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [dw-1:0]     multiplicand,
    input  logic [dw-1:0]     multiplier,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [2*dw-1:0]   product
);

    localparam int unsigned CW = $clog2(dw);

    typedef enum logic [1:0] {StIdle, StCalc, StCorr, StDone} state_e;

    state_e            state_q, state_d;
    logic [dw:0]       a_q, a_d;
    logic [dw-1:0]     q_q, q_d;
    logic [dw-1:0]     m_q, m_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*dw-1:0]   prod_q, prod_d;
    logic [dw:0]       m_ext;
    logic [dw:0]       sum;

    assign m_ext = {m_q[dw-1], m_q};

    // Shared adder: subtract only in the sign-correction step.
    always_comb begin
        sum = a_q;
        if (q_q[0]) begin
            sum = (state_q == StCorr) ? (a_q - m_ext) : (a_q + m_ext);
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    a_d     = '0;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                a_d   = {sum[dw], sum[dw:1]};
                q_d   = {sum[0], q_q[dw-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(dw - 2)) begin
                    state_d = StCorr;
                end
            end
            StCorr: begin
                a_d     = {sum[dw], sum[dw:1]};
                q_d     = {sum[0], q_q[dw-1:1]};
                // Load the result on entry to DONE so it is visible alongside done.
                prod_d  = {sum[dw:1], sum[0], q_q[dw-1:1]};
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign ready   = (state_q == StIdle);
    assign busy    = (state_q == StCalc) || (state_q == StCorr);
    assign done    = (state_q == StDone);
    assign product = prod_q;

endmodule

// File: tb/tb_robertson_seq.sv
// Randomized self-checking bench for robertson_seq against a signed-arithmetic reference.
module tb_robertson_seq;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [DW-1:0]   multiplicand;
    logic [DW-1:0]   multiplier;
    logic            ready;
    logic            busy;
    logic            done;
    logic [2*DW-1:0] product;

    int n_cmp = 0;
    int n_bad = 0;

    robertson_seq #(.dw(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic logic [2*DW-1:0] ref_mul(input logic [DW-1:0] m, input logic [DW-1:0] q);
        logic signed [2*DW-1:0] sm, sq, p;
        sm = $signed({{DW{m[DW-1]}}, m});
        sq = $signed({{DW{q[DW-1]}}, q});
        p  = sm * sq;
        return p;
    endfunction

    function automatic logic [31:0] busy_window(input int first, input int last);
        logic [31:0] mk;
        mk = '0;
        for (int i = first; i <= last; i++) mk[i] = 1'b1;
        return mk;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation starting in cycle 0 and records what the DUT shows in cycles 1..ncyc.
    task automatic do_op(input logic [DW-1:0] m, input logic [DW-1:0] q,
                         input logic [DW-1:0] m2, input logic [DW-1:0] q2,
                         input bit hold, input int pulse_cyc, input int ncyc,
                         output logic [2*DW-1:0] p1, output logic [2*DW-1:0] p2,
                         output int d1, output int d2, output int dcnt,
                         output logic [31:0] bmask, output bit pstable);
        logic [2*DW-1:0] pref;
        int wait_cnt;
        wait_cnt = 0;
        while (!ready && wait_cnt < 50) begin
            next_cycle();
            wait_cnt++;
        end
        n_cmp++;
        if (!ready) begin
            n_bad++;
            $display("FAIL ready_wait: ready=%0b, required 1 within 50 cycles", ready);
        end
        p1 = '0; p2 = '0; d1 = -1; d2 = -1; dcnt = 0; bmask = '0; pstable = 1'b1;
        pref = product;
        start = 1'b1;
        multiplicand = m;
        multiplier = q;
        next_cycle();
        for (int k = 1; k <= ncyc; k++) begin
            if (k == 1) begin
                multiplicand = m2;
                multiplier = q2;
            end
            start = hold ? (k < ncyc) : (k == pulse_cyc);
            #1;
            if (busy) begin
                bmask[k] = 1'b1;
                if (product !== pref) pstable = 1'b0;
            end
            if (done) begin
                dcnt++;
                pref = product;
                if (dcnt == 1) begin
                    d1 = k;
                    p1 = product;
                end else begin
                    d2 = k;
                    p2 = product;
                end
            end
            next_cycle();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        multiplicand = 8'h11;
        multiplier = 8'h22;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b, required 1", ready); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b, required 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b, required 0", done); end
        n_cmp++;
        if (product !== 16'h0000) begin
            n_bad++; $display("FAIL reset_product: got %h, required 0000", product);
        end
    endtask

    task automatic test_basic();
        logic [2*DW-1:0] p1, p2;
        int d1, d2, dc;
        logic [31:0] bm;
        bit ps;
        do_op(8'd3, 8'd5, 8'hAA, 8'h55, 1'b0, 0, DW + 2, p1, p2, d1, d2, dc, bm, ps);
        n_cmp++;
        if (p1 !== 16'h000F) begin n_bad++; $display("FAIL basic_product: got %h, required 000f", p1); end
        n_cmp++;
        if (d1 != DW + 1) begin n_bad++; $display("FAIL basic_latency: done cycle %0d, required %0d", d1, DW + 1); end
        n_cmp++;
        if (dc != 1) begin n_bad++; $display("FAIL basic_done_count: got %0d, required 1", dc); end
        n_cmp++;
        if (bm !== busy_window(1, DW)) begin
            n_bad++; $display("FAIL basic_busy_cycles: got %h, required %h", bm, busy_window(1, DW));
        end
        n_cmp++;
        if (!ps) begin n_bad++; $display("FAIL basic_product_stable: product changed while busy, required stable"); end
    endtask

    task automatic test_negative();
        logic [2*DW-1:0] p1, p2;
        int d1, d2, dc;
        logic [31:0] bm;
        bit ps;
        do_op(8'hFD, 8'd5, 8'h01, 8'h01, 1'b0, 0, DW + 2, p1, p2, d1, d2, dc, bm, ps);
        n_cmp++;
        if (p1 !== 16'hFFF1) begin n_bad++; $display("FAIL neg_m_product: got %h, required fff1", p1); end
        do_op(8'd5, 8'hFD, 8'h7F, 8'h7F, 1'b0, 0, DW + 2, p1, p2, d1, d2, dc, bm, ps);
        n_cmp++;
        if (p1 !== 16'hFFF1) begin n_bad++; $display("FAIL neg_q_product: got %h, required fff1", p1); end
    endtask

    task automatic test_extremes();
        logic [2*DW-1:0] p1, p2;
        int d1, d2, dc;
        logic [31:0] bm;
        bit ps;
        do_op(8'h80, 8'h80, 8'h00, 8'h00, 1'b0, 0, DW + 2, p1, p2, d1, d2, dc, bm, ps);
        n_cmp++;
        if (p1 !== 16'h4000) begin n_bad++; $display("FAIL min_min_product: got %h, required 4000", p1); end
        do_op(8'h80, 8'h7F, 8'hFF, 8'hFF, 1'b0, 0, DW + 2, p1, p2, d1, d2, dc, bm, ps);
        n_cmp++;
        if (p1 !== 16'hC080) begin n_bad++; $display("FAIL min_max_product: got %h, required c080", p1); end
    endtask

    task automatic test_reset_mid();
        logic [2*DW-1:0] p1, p2;
        int d1, d2, dc;
        logic [31:0] bm;
        bit ps;
        start = 1'b1;
        multiplicand = 8'd100;
        multiplier = 8'd77;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        // Cycle 4 is the 4th CALC cycle.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        n_cmp++;
        if (ready !== 1'b1) begin n_bad++; $display("FAIL midreset_ready: got %0b, required 1", ready); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %0b, required 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL midreset_done: got %0b, required 0", done); end
        n_cmp++;
        if (product !== 16'h0000) begin
            n_bad++; $display("FAIL midreset_product: got %h, required 0000", product);
        end
        do_op(8'd7, 8'd7, 8'h33, 8'hC4, 1'b0, 0, DW + 2, p1, p2, d1, d2, dc, bm, ps);
        n_cmp++;
        if (p1 !== 16'h0031) begin n_bad++; $display("FAIL midreset_7x7: got %h, required 0031", p1); end
        n_cmp++;
        if (d1 != DW + 1) begin n_bad++; $display("FAIL midreset_latency: done cycle %0d, required %0d", d1, DW + 1); end
    endtask

    task automatic test_ignore_start();
        logic [2*DW-1:0] p1, p2;
        int d1, d2, dc;
        logic [31:0] bm;
        bit ps;
        do_op(8'd2, 8'd3, 8'd9, 8'd9, 1'b0, 3, DW + 4, p1, p2, d1, d2, dc, bm, ps);
        n_cmp++;
        if (p1 !== 16'h0006) begin n_bad++; $display("FAIL ignore_start_product: got %h, required 0006", p1); end
        n_cmp++;
        if (dc != 1) begin n_bad++; $display("FAIL ignore_start_done_count: got %0d, required 1", dc); end
        n_cmp++;
        if (d1 != DW + 1) begin n_bad++; $display("FAIL ignore_start_latency: got %0d, required %0d", d1, DW + 1); end
    endtask

    task automatic test_back_to_back();
        logic [2*DW-1:0] p1, p2;
        int d1, d2, dc;
        logic [31:0] bm;
        bit ps;
        do_op(8'hFF, 8'hFF, 8'd4, 8'hFE, 1'b1, 0, 2 * DW + 4, p1, p2, d1, d2, dc, bm, ps);
        n_cmp++;
        if (p1 !== 16'h0001) begin n_bad++; $display("FAIL b2b_first_product: got %h, required 0001", p1); end
        n_cmp++;
        if (p2 !== 16'hFFF8) begin n_bad++; $display("FAIL b2b_second_product: got %h, required fff8", p2); end
        n_cmp++;
        if (dc != 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d, required 2", dc); end
        n_cmp++;
        if (d2 - d1 != DW + 2) begin
            n_bad++; $display("FAIL b2b_spacing: got %0d, required %0d", d2 - d1, DW + 2);
        end
        n_cmp++;
        if (!ps) begin n_bad++; $display("FAIL b2b_product_stable: product changed while busy, required stable"); end
    endtask

    task automatic test_random();
        logic [2*DW-1:0] p1, p2, exp;
        logic [DW-1:0] m, q;
        int d1, d2, dc;
        logic [31:0] bm;
        bit ps;
        for (int i = 0; i < 30; i++) begin
            m = DW'($urandom);
            q = DW'($urandom);
            exp = ref_mul(m, q);
            do_op(m, q, DW'($urandom), DW'($urandom), 1'b0, $urandom_range(2, DW + 1), DW + 2,
                  p1, p2, d1, d2, dc, bm, ps);
            n_cmp++;
            if (p1 !== exp || dc != 1 || d1 != DW + 1 || !ps) begin
                n_bad++;
                $display("FAIL random_%0d m=%h q=%h: got product %h done@%0d x%0d stable=%0b, required %h done@%0d x1 stable=1",
                         i, m, q, p1, d1, dc, ps, exp, DW + 1);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        #1;
        test_reset();
        test_basic();
        test_negative();
        test_extremes();
        test_reset_mid();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/robertson_seq.md
ROBERTSON_SEQ -- requirements
Module: robertson_seq

Interface
REQ-001 The module SHALL have parameter dw, default 8, meaning operand data width in bits (dw >= 2).
REQ-002 The module SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1, a level-sampled request to begin a multiply.
REQ-005 The module SHALL have port multiplicand, input, dw, the signed two's-complement operand M.
REQ-006 The module SHALL have port multiplier, input, dw, the signed two's-complement operand Q.
REQ-007 The module SHALL have port ready, output, 1, high only in state IDLE.
REQ-008 The module SHALL have port busy, output, 1, high only in states CALC and CORR.
REQ-009 The module SHALL have port done, output, 1, a one-cycle pulse, high only in state DONE.
REQ-010 The module SHALL have port product, output, 2*dw, the signed product M*Q.

Function
REQ-011 The module SHALL be a Robertson signed shift-add multiplier: FSM plus counter sequencing one shared add/subtract unit, one iteration per clock.
REQ-012 The FSM SHALL have exactly four states: IDLE, CALC, CORR, DONE.
REQ-013 In IDLE with start=1, the module SHALL capture M and Q, clear accumulator A (dw+1 bits) and the iteration counter, and enter CALC.
REQ-014 In IDLE with start=0, the module SHALL remain in IDLE with all registers unchanged.
REQ-015 Arithmetic SHALL use dw+1-bit sign-extended operands, so the add/subtract never overflows.
REQ-016 Each CALC cycle SHALL set A = A + sext(M) if Q[0]=1, else leave A, then arithmetic-right-shift the combined {A,Q} by one bit, then increment the counter.
REQ-017 After exactly dw-1 CALC cycles, the FSM SHALL enter CORR.
REQ-018 The CORR cycle SHALL set A = A - sext(M) if Q[0]=1 (multiplier sign correction), else leave A, then arithmetic-right-shift {A,Q}, then enter DONE.
REQ-019 DONE SHALL last exactly one cycle, during which it asserts done and loads product = {A[dw-1:0], Q}, then returns to IDLE.
REQ-020 Latency: if start is sampled in cycle 0, done SHALL be high in cycle dw+1 (cycle 9 for dw=8).
REQ-021 product SHALL hold its value from DONE until the next DONE or reset; it SHALL NOT change during CALC/CORR.
REQ-022 start SHALL be ignored in CALC, CORR and DONE.
REQ-023 Operand input changes after capture SHALL NOT affect the running operation.
REQ-024 If start is held high continuously, a new operation SHALL begin in the IDLE cycle immediately following DONE, using the operands present in that cycle.
REQ-025 Extreme operands SHALL produce exact results: -2^(dw-1) * -2^(dw-1) = 2^(2dw-2), with no wrap.

Reset
REQ-026 When reset=1 at a rising edge, in any state including mid-CALC, the module SHALL enter IDLE and clear A, Q, M, the counter and product to 0.
REQ-027 Reset SHALL take priority over start in the same cycle.
REQ-028 In the cycle after reset: ready=1, busy=0, done=0, product=0.

Verification
REQ-029 The bench SHALL cover dw=8, M=3, Q=5, start in cycle 0 -> busy in cycles 1-8, done=1 only in cycle 9, product=0x000F.
REQ-030 The bench SHALL cover M=-3 (0xFD), Q=5 -> product=0xFFF1; also M=5, Q=-3 (0xFD) -> product=0xFFF1, with the CORR subtract exercised.
REQ-031 The bench SHALL cover M=0x80, Q=0x80 -> product=0x4000; also M=0x80, Q=0x7F -> product=0xC080.
REQ-032 The bench SHALL cover reset asserted in the 4th CALC cycle -> next cycle ready=1, busy=0, done=0, product=0; then M=7, Q=7 -> product=0x0031 nine cycles after start.
REQ-033 The bench SHALL cover start with M=2, Q=3, then start pulsed again in cycle 3 with M=9, Q=9 -> second start ignored, product=0x0006, single done pulse.
REQ-034 The bench SHALL cover start held high over two operations (M=-1, Q=-1, then M=4, Q=-2 present in the IDLE cycle) -> products 0x0001 then 0xFFF8, done pulses 10 cycles apart.
